// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller: load-use stalls, branch/jump flush, mul/div interlock
// and a saturating stall-cycle counter.
module hazard_unit_mc #(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned OPC_W    = 6,
   parameter logic [OPC_W-1:0] OPC_BEQ = OPC_W'(6'b000100),
   parameter logic [OPC_W-1:0] OPC_BNE = OPC_W'(6'b000101),
   parameter logic [OPC_W-1:0] OPC_J   = OPC_W'(6'b000010),
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned MD_LAT   = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [OPC_W-1:0] opc,
   input  logic             eq,
   input  logic             id_md_start,
   input  logic             id_md_read,
   output logic             pc_ld,
   output logic             if_id_ld,
   output logic             ctrl_zero,
   output logic             flush,
   output logic             is_beq,
   output logic             is_bne,
   output logic             is_jmp,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned LD_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam int unsigned MD_W = $clog2(MD_LAT + 1);

   typedef enum logic {RUN, LSTALL} state_t;

   state_t          state, state_nxt;
   logic [LD_W-1:0] ld_cnt, ld_cnt_nxt;
   logic [MD_W-1:0] md_cnt, md_cnt_nxt;
   logic            lw_hit, md_stall, stall, take, busy_raw, md_issue;

   assign is_beq = (opc == OPC_BEQ);
   assign is_bne = (opc == OPC_BNE);
   assign is_jmp = (opc == OPC_J);

   // Register 0 is hard-wired and never a real dependency
   assign lw_hit = ex_memread && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   assign busy_raw = (md_cnt != '0);
   assign md_stall = busy_raw && (id_md_start || id_md_read);
   assign stall    = !rst && ((lw_hit && (state == RUN)) || (state == LSTALL) || md_stall);
   assign take     = (is_beq && eq) || (is_bne && !eq) || is_jmp;

   // Branches only resolve when not stalled, since eq may be stale during a stall
   assign pc_ld     = !stall;
   assign if_id_ld  = !stall;
   assign flush     = !rst && !stall && take;
   assign ctrl_zero = stall || flush;
   assign md_busy   = !rst && busy_raw;
   assign md_issue  = id_md_start && !busy_raw && !stall;

   always_comb begin
      state_nxt  = state;
      ld_cnt_nxt = ld_cnt;
      case (state)
         RUN: begin
            if (lw_hit && (LOAD_LAT > 1)) begin
               state_nxt  = LSTALL;
               ld_cnt_nxt = LD_W'(LOAD_LAT - 1);
            end
         end
         LSTALL: begin
            ld_cnt_nxt = ld_cnt - LD_W'(1);
            if (ld_cnt == LD_W'(1)) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      md_cnt_nxt = md_cnt;
      if (md_issue)      md_cnt_nxt = MD_W'(MD_LAT);
      else if (busy_raw) md_cnt_nxt = md_cnt - MD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         ld_cnt    <= '0;
         md_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         state  <= state_nxt;
         ld_cnt <= ld_cnt_nxt;
         md_cnt <= md_cnt_nxt;
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: three parameter sets driven in parallel and checked
// against a cycle-timestamp reference model.
module tb_hazard_unit_mc;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, ex_memread, id_uses_rt, eq, id_md_start, id_md_read;
   logic [4:0] ex_rt, id_rs, id_rt;
   logic [5:0] opc;

   logic        pc_ld [3], if_id_ld [3], ctrl_zero [3], flush [3];
   logic        is_beq [3], is_bne [3], is_jmp [3], md_busy [3];
   logic [15:0] sc0, sc1;
   logic [3:0]  sc2;

   hazard_unit_mc #(.LOAD_LAT(1), .MD_LAT(4), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs),
      .id_rt(id_rt), .id_uses_rt(id_uses_rt), .opc(opc), .eq(eq),
      .id_md_start(id_md_start), .id_md_read(id_md_read),
      .pc_ld(pc_ld[0]), .if_id_ld(if_id_ld[0]), .ctrl_zero(ctrl_zero[0]), .flush(flush[0]),
      .is_beq(is_beq[0]), .is_bne(is_bne[0]), .is_jmp(is_jmp[0]), .md_busy(md_busy[0]),
      .stall_cnt(sc0));

   hazard_unit_mc #(.LOAD_LAT(3), .MD_LAT(4), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs),
      .id_rt(id_rt), .id_uses_rt(id_uses_rt), .opc(opc), .eq(eq),
      .id_md_start(id_md_start), .id_md_read(id_md_read),
      .pc_ld(pc_ld[1]), .if_id_ld(if_id_ld[1]), .ctrl_zero(ctrl_zero[1]), .flush(flush[1]),
      .is_beq(is_beq[1]), .is_bne(is_bne[1]), .is_jmp(is_jmp[1]), .md_busy(md_busy[1]),
      .stall_cnt(sc1));

   hazard_unit_mc #(.LOAD_LAT(1), .MD_LAT(1), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst), .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs),
      .id_rt(id_rt), .id_uses_rt(id_uses_rt), .opc(opc), .eq(eq),
      .id_md_start(id_md_start), .id_md_read(id_md_read),
      .pc_ld(pc_ld[2]), .if_id_ld(if_id_ld[2]), .ctrl_zero(ctrl_zero[2]), .flush(flush[2]),
      .is_beq(is_beq[2]), .is_bne(is_bne[2]), .is_jmp(is_jmp[2]), .md_busy(md_busy[2]),
      .stall_cnt(sc2));

   // Reference model: stalls and busy windows tracked as absolute cycle numbers
   int unsigned load_lat [3] = '{1, 3, 1};
   int unsigned md_lat   [3] = '{4, 4, 1};
   int unsigned cnt_max  [3] = '{65535, 65535, 15};
   int unsigned ld_end   [3];
   int unsigned md_free  [3];
   int unsigned cnt_m    [3];
   int unsigned cyc;
   int          n_cmp, n_err;

   task automatic step(input logic r, input logic mr, input int er, input int rs,
                       input int rt, input logic ur, input int op, input logic e,
                       input logic ms, input logic md);
      logic       in_load, busy, hit, stl, take, fl;
      logic [7:0] exp_f, obs_f;
      int unsigned obs_c;
      rst = r; ex_memread = mr; ex_rt = 5'(er); id_rs = 5'(rs); id_rt = 5'(rt);
      id_uses_rt = ur; opc = 6'(op); eq = e; id_md_start = ms; id_md_read = md;
      #2;
      for (int i = 0; i < 3; i++) begin
         in_load = cyc < ld_end[i];
         busy    = cyc < md_free[i];
         hit     = mr && (er != 0) && ((er == rs) || (ur && (er == rt)));
         stl     = !r && (in_load || hit || (busy && (ms || md)));
         take    = ((op == 4) && e) || ((op == 5) && !e) || (op == 2);
         fl      = !r && !stl && take;
         exp_f   = {!stl, !stl, stl || fl, fl, op == 4, op == 5, op == 2, !r && busy};
         obs_f   = {pc_ld[i], if_id_ld[i], ctrl_zero[i], flush[i],
                    is_beq[i], is_bne[i], is_jmp[i], md_busy[i]};
         n_cmp++;
         assert (obs_f === exp_f) else begin
            n_err++;
            $error("FAIL flags dut%0d cyc %0d: observed %b expected %b", i, cyc, obs_f, exp_f);
         end
         obs_c = (i == 0) ? 32'(sc0) : (i == 1) ? 32'(sc1) : 32'(sc2);
         n_cmp++;
         assert (obs_c === cnt_m[i]) else begin
            n_err++;
            $error("FAIL stall_cnt dut%0d cyc %0d: observed %0d expected %0d", i, cyc, obs_c, cnt_m[i]);
         end
         if (r) begin
            ld_end[i] = 0; md_free[i] = 0; cnt_m[i] = 0;
         end else begin
            if (!in_load && hit) ld_end[i] = cyc + load_lat[i];
            if (ms && !busy && !stl) md_free[i] = cyc + 1 + md_lat[i];
            if (stl && (cnt_m[i] < cnt_max[i])) cnt_m[i]++;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int ops [5] = '{4, 5, 2, 0, 35};
      n_cmp = 0; n_err = 0; cyc = 0;
      for (int i = 0; i < 3; i++) begin ld_end[i] = 0; md_free[i] = 0; cnt_m[i] = 0; end
      rst = 1; ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
      opc = 0; eq = 0; id_md_start = 0; id_md_read = 0;
      @(posedge clk); #1;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Single load-use hit on rt, then release
      step(0, 1, 18, 3, 18, 1, 0, 0, 0, 0);
      idle(4);
      // Hazard held for three cycles
      repeat (3) step(0, 1, 18, 18, 0, 0, 0, 0, 0, 0);
      idle(3);
      // Register 0 and unused rt never stall
      step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 7, 3, 7, 0, 0, 0, 0, 0);
      // Branch and jump decode
      step(0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
      // Branch while a load stall is active, held until it resolves
      step(0, 1, 9, 9, 0, 0, 4, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
      idle(2);
      // Mul/div issue, read while busy, back-to-back issue
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(6);
      // Mul/div start during a load stall
      step(0, 1, 4, 4, 0, 0, 0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(6);
      // Reset mid-LSTALL and mid-busy
      step(0, 1, 6, 6, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // Long held stall saturates the narrow counter
      repeat (20) step(0, 1, 12, 12, 0, 0, 0, 0, 0, 0);
      idle(3);
      // Randomized traffic biased towards hazards
      for (int k = 0; k < 800; k++) begin
         step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
              $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
